dmem_sched: RTL
===============

// Module: dmem_sched
// PURPOSE
//  Single-port scheduler in front of data memory. Shares the memory port between
//  the load FU (speculative, tagged) and the store commit path (non-speculative).
//  Tracks in-flight loads through the fixed memory latency, returns data with ROB tag
//  on the writeback bus, and squashes in-flight loads on flush.
// PARAMETERS
//  TAG_W      6  ROB tag width
//  MEM_LAT    2  cycles from mem_issued high to mem_valid high (fixed, >=1)
//  STARVE_MAX 4  consecutive store-denied cycles before store is forced
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  flush        in   1       mispredict flush; kills all speculative loads
//  ld_valid     in   1       load request
//  ld_ready     out  1       load accepted when ld_valid&ld_ready
//  ld_addr      in   32      byte address
//  ld_func3     in   3       3'b100 LBU, 3'b010 LW
//  ld_tag       in   TAG_W   ROB tag of load
//  st_valid     in   1       committed store request
//  st_ready     out  1       store accepted when st_valid&st_ready
//  st_addr      in   32      byte address
//  st_data      in   32      store data (SB uses [7:0])
//  st_func3     in   3       3'b000 SB, 3'b010 SW
//  mem_issued   out  1       one-cycle request strobe to memory
//  mem_opcode   out  7       7'b0000011 load, 7'b0100011 store
//  mem_func3    out  3       forwarded func3 of granted request
//  mem_addr     out  32      address of granted request
//  mem_we       out  1       1 = store
//  mem_wdata    out  32      store data
//  mem_valid    in   1       memory load-return strobe
//  mem_data     in   32      memory load data
//  wb_valid     out  1       load result valid (one cycle)
//  wb_tag       out  TAG_W   ROB tag of result
//  wb_data      out  32      load result
//  busy         out  1       any load in flight
// BEHAVIOUR
//  Reset: all outputs 0; in-flight pipe cleared; starve counter 0.
//  Outputs mem_* registered: grant in cycle N -> mem_issued=1 in N+1, held 1 cycle.
//  One grant per cycle max; ready outputs are combinational grant signals.
//  Arbitration, in order:
//   1 flush=1: ld_ready=0; store may still be granted.
//   2 st_valid & (starve==STARVE_MAX | !ld_valid | ld_addr[31:2]==st_addr[31:2]):
//     grant store (same-word conflict -> store first, preserves order).
//   3 else ld_valid: grant load; st_ready=0; starve++ if st_valid (saturate).
//  starve resets to 0 on store grant or !st_valid.
//  In-flight pipe: MEM_LAT+1 entries of {v,tag}; load issue pushes v=1, stores and
//   idle cycles push v=0; shifts every cycle.
//  flush clears v of all entries (including one issued same cycle); memory still
//   returns data but wb_valid stays 0 for killed entries.
//  wb_valid=1 next cycle after mem_valid when head entry v=1; wb_data=mem_data,
//   wb_tag=head tag. mem_valid with head v=0 -> dropped silently.
//  Assertion: mem_valid must coincide with a load entry at head (v or killed).
//  busy = OR of live v bits.
//  Reset mid-operation: pipe cleared, no wb_valid issued for lost loads.
//  Address/width: no alignment check; LW at addr passes as-is.
// TESTING
//  Lone LW addr 0x10 tag 5 -> mem_issued at +1, wb_valid at +MEM_LAT+2, tag 5, mem data.
//  ld 0x20 + st 0x40 same cycle -> load first, store next cycle; starve=1 then 0.
//  ld 0x44 + SW 0x46 same cycle -> store granted first (same word), load next cycle.
//  Continuous loads + st_valid -> store forced on 5th cycle (STARVE_MAX=4).
//  LW tag 3 issued, flush 1 cycle later -> no wb_valid; busy drops to 0.
//  reset low during 2 in-flight loads -> all outputs 0, no wb_valid after release.

Source files
------------

// File: rtl/dmem_sched_if.sv
// Bus bundle between the data-memory scheduler and its neighbours: load FU,
// store commit path, memory port and load writeback bus.
interface dmem_sched_if #(
  parameter int TAG_W = 6
) ();
  // load request
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [2:0]       ld_func3;
  logic [TAG_W-1:0] ld_tag;
  // committed store request
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [2:0]       st_func3;
  // memory port
  logic             mem_issued;
  logic [6:0]       mem_opcode;
  logic [2:0]       mem_func3;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic             mem_valid;
  logic [31:0]      mem_data;
  // load writeback
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;

  // environment side: requesters, memory and writeback consumer
  modport master (
    output ld_valid, ld_addr, ld_func3, ld_tag,
    output st_valid, st_addr, st_data, st_func3,
    output mem_valid, mem_data,
    input  ld_ready, st_ready,
    input  mem_issued, mem_opcode, mem_func3, mem_addr, mem_we, mem_wdata,
    input  wb_valid, wb_tag, wb_data
  );

  // scheduler side
  modport slave (
    input  ld_valid, ld_addr, ld_func3, ld_tag,
    input  st_valid, st_addr, st_data, st_func3,
    input  mem_valid, mem_data,
    output ld_ready, st_ready,
    output mem_issued, mem_opcode, mem_func3, mem_addr, mem_we, mem_wdata,
    output wb_valid, wb_tag, wb_data
  );
endinterface

// File: rtl/dmem_sched.sv
// Single-port data-memory scheduler. Arbitrates loads vs committed stores,
// tracks loads through the fixed memory latency and returns tagged results.
module dmem_sched #(
  parameter int TAG_W      = 6,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,   // async, active low
  input  logic         flush_i,
  dmem_sched_if.slave  bus,
  output logic         busy_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // ld marks any load slot (even squashed) so a memory return can be matched
  typedef struct packed {
    logic             ld;
    logic             v;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t [MEM_LAT:0] pipe_q, pipe_d;
  ent_t             head;
  logic [SW-1:0]    starve_q, starve_d;
  logic             st_gnt, ld_gnt, same_word;

  logic             mem_issued_q, mem_we_q;
  logic [6:0]       mem_opcode_q;
  logic [2:0]       mem_func3_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic             wb_valid_q;
  logic [TAG_W-1:0] wb_tag_q;
  logic [31:0]      wb_data_q;

  assign head = pipe_q[MEM_LAT];

  // grant: store wins when starved, uncontested, or hitting the load's word
  always_comb begin
    same_word = (bus.ld_addr[31:2] == bus.st_addr[31:2]);
    st_gnt    = reset_i & bus.st_valid &
                (flush_i | (starve_q == SW'(STARVE_MAX)) | !bus.ld_valid | same_word);
    ld_gnt    = reset_i & bus.ld_valid & !flush_i & !st_gnt;
    starve_d  = starve_q;
    if (!bus.st_valid || st_gnt)
      starve_d = '0;
    else if (ld_gnt && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  assign bus.ld_ready = ld_gnt;
  assign bus.st_ready = st_gnt;

  // in-flight shift: new slot at [0], head at [MEM_LAT]; flush squashes all
  always_comb begin
    pipe_d        = '0;
    pipe_d[0].ld  = ld_gnt;
    pipe_d[0].v   = ld_gnt;
    pipe_d[0].tag = ld_gnt ? bus.ld_tag : '0;
    for (int i = 1; i <= MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    if (flush_i)
      for (int i = 0; i <= MEM_LAT; i++) pipe_d[i].v = 1'b0;
  end

  // busy while any live load remains in flight
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i <= MEM_LAT; i++) busy_o = busy_o | pipe_q[i].v;
  end

  // state registers: starve counter and in-flight pipe
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      starve_q <= '0;
      pipe_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pipe_q   <= pipe_d;
    end
  end

  // registered memory request, one-cycle strobe after grant
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mem_issued_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_opcode_q <= '0;
      mem_func3_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_issued_q <= st_gnt | ld_gnt;
      mem_we_q     <= st_gnt;
      mem_opcode_q <= st_gnt ? OP_STORE : (ld_gnt ? OP_LOAD : 7'd0);
      mem_func3_q  <= st_gnt ? bus.st_func3 : (ld_gnt ? bus.ld_func3 : 3'd0);
      mem_addr_q   <= st_gnt ? bus.st_addr : (ld_gnt ? bus.ld_addr : 32'd0);
      mem_wdata_q  <= st_gnt ? bus.st_data : 32'd0;
    end
  end

  // writeback one cycle after the memory return, only for live head slots
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= bus.mem_valid & head.v & !flush_i;
      if (bus.mem_valid) begin
        wb_tag_q  <= head.tag;
        wb_data_q <= bus.mem_data;
      end
    end
  end

  assign bus.mem_issued = mem_issued_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_opcode = mem_opcode_q;
  assign bus.mem_func3  = mem_func3_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_tag     = wb_tag_q;
  assign bus.wb_data    = wb_data_q;

  // a memory return must land on a load slot, live or squashed
  a_ret_on_load: assert property (@(posedge clk_i) disable iff (!reset_i)
                                  bus.mem_valid |-> head.ld);
endmodule
